mem_access_guard: RTL and testbench

Parametrised data-address checker for the MEM stage of the pipelined MIPS CPU. Each load/store is checked against NREG address regions with per-region direction and access-size permissions, alignment and store-protected words. The verdict is registered with one-cycle latency, aligned to the EX/MEM boundary. The first fault's address and PC are held in a sticky capture register until CP0 acknowledges it, and later faults are counted.

---
 rtl/mem_access_guard_if.sv | 38 +++
 rtl/mem_access_guard.sv | 165 ++++++++++++++++
 tb/tb_mem_access_guard.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_guard_if.sv
// MEM-stage access-check bus: request side from the pipeline, verdict and
// sticky fault capture back toward CP0.
interface mem_access_guard_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_pc;
  logic              stall;
  logic              flush;
  logic              exc_ack;

  logic              chk_valid;
  logic              chk_exc;
  logic [4:0]        chk_exccode;
  logic [2:0]        chk_cause;
  logic [2:0]        chk_region;
  logic              fault_pending;
  logic [ADDR_W-1:0] bad_vaddr;
  logic [31:0]       bad_pc;
  logic [4:0]        bad_code;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_pc, stall, flush, exc_ack,
    input  chk_valid, chk_exc, chk_exccode, chk_cause, chk_region,
           fault_pending, bad_vaddr, bad_pc, bad_code, drop_cnt
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_pc, stall, flush, exc_ack,
    output chk_valid, chk_exc, chk_exccode, chk_cause, chk_region,
           fault_pending, bad_vaddr, bad_pc, bad_code, drop_cnt
  );
endinterface

// File: rtl/mem_access_guard.sv
// Data-address guard for the MEM stage: region/permission/alignment check,
// one-cycle registered verdict and a sticky first-fault capture for CP0.
module mem_access_guard #(
  parameter int                     ADDR_W    = 32,
  parameter int                     NREG      = 3,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE  = {32'h7f10, 32'h7f00, 32'h0},
  parameter logic [NREG*ADDR_W-1:0] REG_LIMIT = {32'h7f1b, 32'h7f0b, 32'h2fff},
  parameter logic [NREG*5-1:0]      REG_PERM  = {5'b00111, 5'b00111, 5'b11111},
  parameter int                     NRO       = 2,
  parameter logic [NRO*ADDR_W-1:0]  RO_ADDR   = {32'h7f18, 32'h7f08},
  parameter int                     CNT_W     = 8
) (
  input logic               clk,
  input logic               reset,
  mem_access_guard_if.slave bus
);

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_UNMAPPED  = 3'd1,
    CAUSE_DIRECTION = 3'd2,
    CAUSE_SIZE      = 3'd3,
    CAUSE_MISALIGN  = 3'd4,
    CAUSE_STORE_RO  = 3'd5
  } cause_e;

  typedef struct packed {
    logic              valid;
    logic              exc;
    logic [4:0]        code;
    cause_e            cause;
    logic [2:0]        region;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       pc;
  } chk_t;

  logic       hit;
  logic [2:0] hit_idx;
  logic [4:0] hit_perm;
  logic       ro_hit;
  logic       dir_ok;
  logic       size_ok;
  logic       aligned;
  cause_e     cause;

  chk_t              chk_q, chk_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] vaddr_q, vaddr_d;
  logic [31:0]       pc_q, pc_d;
  logic [4:0]        code_q, code_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              captured_q, captured_d;
  logic              new_fault;

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_perm = '0;
    // Walk downward so the lowest matching region is the one left standing.
    for (int i = NREG - 1; i >= 0; i--) begin
      if (bus.req_addr >= REG_BASE[i*ADDR_W +: ADDR_W] &&
          bus.req_addr <= REG_LIMIT[i*ADDR_W +: ADDR_W]) begin
        hit      = 1'b1;
        hit_idx  = 3'(i);
        hit_perm = REG_PERM[i*5 +: 5];
      end
    end

    ro_hit = 1'b0;
    for (int j = 0; j < NRO; j++) begin
      if (bus.req_addr == RO_ADDR[j*ADDR_W +: ADDR_W]) ro_hit = 1'b1;
    end

    dir_ok = bus.req_we ? hit_perm[1] : hit_perm[0];
    case (bus.req_size)
      2'd0:    size_ok = hit_perm[4];
      2'd1:    size_ok = hit_perm[3];
      2'd2:    size_ok = hit_perm[2];
      default: size_ok = 1'b0;
    endcase
    aligned = !((bus.req_size == 2'd1 && bus.req_addr[0]) ||
                (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00));

    if (!hit)                      cause = CAUSE_UNMAPPED;
    else if (!dir_ok)              cause = CAUSE_DIRECTION;
    else if (!size_ok)             cause = CAUSE_SIZE;
    else if (!aligned)             cause = CAUSE_MISALIGN;
    else if (bus.req_we && ro_hit) cause = CAUSE_STORE_RO;
    else                           cause = CAUSE_NONE;
  end

  always_comb begin
    chk_d = chk_q;
    if (bus.flush) begin
      chk_d = '0;
    end else if (!bus.stall) begin
      chk_d       = '0;
      chk_d.valid = bus.req_valid;
      if (bus.req_valid) begin
        chk_d.exc    = (cause != CAUSE_NONE);
        chk_d.code   = (cause == CAUSE_NONE) ? 5'd0 : (bus.req_we ? 5'd5 : 5'd4);
        chk_d.cause  = cause;
        chk_d.region = hit_idx;
        chk_d.addr   = bus.req_addr;
        chk_d.pc     = bus.req_pc;
      end
    end
  end

  // A stalled faulting entry is presented for several cycles but reported once.
  assign new_fault  = chk_q.exc && !captured_q;
  assign captured_d = (bus.stall && !bus.flush) ? (captured_q | chk_q.exc) : 1'b0;

  always_comb begin
    pending_d = pending_q;
    vaddr_d   = vaddr_q;
    pc_d      = pc_q;
    code_d    = code_q;
    drop_d    = drop_q;
    if (new_fault && (!pending_q || bus.exc_ack)) begin
      pending_d = 1'b1;
      vaddr_d   = chk_q.addr;
      pc_d      = chk_q.pc;
      code_d    = chk_q.code;
    end else if (new_fault) begin
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end else if (bus.exc_ack) begin
      pending_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q      <= '0;
      pending_q  <= 1'b0;
      vaddr_q    <= '0;
      pc_q       <= '0;
      code_q     <= '0;
      drop_q     <= '0;
      captured_q <= 1'b0;
    end else begin
      chk_q      <= chk_d;
      pending_q  <= pending_d;
      vaddr_q    <= vaddr_d;
      pc_q       <= pc_d;
      code_q     <= code_d;
      drop_q     <= drop_d;
      captured_q <= captured_d;
    end
  end

  assign bus.chk_valid     = chk_q.valid;
  assign bus.chk_exc       = chk_q.exc;
  assign bus.chk_exccode   = chk_q.code;
  assign bus.chk_cause     = chk_q.cause;
  assign bus.chk_region    = chk_q.region;
  assign bus.fault_pending = pending_q;
  assign bus.bad_vaddr     = vaddr_q;
  assign bus.bad_pc        = pc_q;
  assign bus.bad_code      = code_q;
  assign bus.drop_cnt      = drop_q;

endmodule

// File: tb/tb_mem_access_guard.sv
// Scoreboard bench for mem_access_guard: directed scenarios plus randomized
// traffic against a rule-level reference model of the default memory map.
module tb_mem_access_guard;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_guard_if #(.ADDR_W(32), .CNT_W(8)) bus ();

  mem_access_guard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic        exc;
    logic [4:0]  code;
    logic [2:0]  cause;
    logic [2:0]  region;
    logic        pending;
    logic [31:0] vaddr;
    logic [31:0] pc;
    logic [4:0]  bcode;
    logic [7:0]  drop;
  } exp_t;

  // Default memory map: region 0 is general RAM, regions 1 and 2 are word-only MMIO.
  int unsigned rg_base  [3] = '{32'h0000, 32'h7f00, 32'h7f10};
  int unsigned rg_limit [3] = '{32'h2fff, 32'h7f0b, 32'h7f1b};
  bit          rg_load  [3] = '{1'b1, 1'b1, 1'b1};
  bit          rg_store [3] = '{1'b1, 1'b1, 1'b1};
  bit          rg_byte  [3] = '{1'b1, 1'b0, 1'b0};
  bit          rg_half  [3] = '{1'b1, 1'b0, 1'b0};
  bit          rg_word  [3] = '{1'b1, 1'b1, 1'b1};
  int unsigned ro_list  [2] = '{32'h7f08, 32'h7f18};

  exp_t        sb_q[$];
  exp_t        m;
  logic [31:0] m_addr, m_pc;
  bit          m_reported;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void ref_check(input logic [31:0] a, input logic we, input logic [1:0] sz,
                                    output int cause, output int region);
    bit size_allowed;
    region = -1;
    for (int i = 0; i < 3; i++) begin
      if (region < 0 && a >= rg_base[i] && a <= rg_limit[i]) region = i;
    end
    if (region < 0) begin
      cause  = 1;
      region = 0;
      return;
    end
    size_allowed = (sz == 0) ? rg_byte[region] : (sz == 1) ? rg_half[region] :
                   (sz == 2) ? rg_word[region] : 1'b0;
    if (we ? !rg_store[region] : !rg_load[region])               cause = 2;
    else if (!size_allowed)                                      cause = 3;
    else if ((sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) cause = 4;
    else if (we && (a == ro_list[0] || a == ro_list[1]))         cause = 5;
    else                                                         cause = 0;
  endfunction

  function automatic void model_reset();
    m          = '{default: '0};
    m_addr     = '0;
    m_pc       = '0;
    m_reported = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently on the bus.
  task automatic model_step();
    exp_t n = m;
    bit   first_show;
    int   c, r;
    first_show = m.exc && !m_reported;
    if (first_show && (!m.pending || bus.exc_ack)) begin
      n.pending = 1'b1;
      n.vaddr   = m_addr;
      n.pc      = m_pc;
      n.bcode   = m.code;
    end else if (first_show) begin
      if (m.drop != 8'hff) n.drop = m.drop + 8'd1;
    end else if (bus.exc_ack) begin
      n.pending = 1'b0;
    end
    m_reported = (bus.stall && !bus.flush) ? (m_reported || m.exc) : 1'b0;

    if (bus.flush || (!bus.stall && !bus.req_valid)) begin
      n.valid  = bus.flush ? 1'b0 : bus.req_valid;
      n.exc    = 1'b0;
      n.code   = '0;
      n.cause  = '0;
      n.region = '0;
      m_addr   = '0;
      m_pc     = '0;
    end else if (!bus.stall) begin
      ref_check(bus.req_addr, bus.req_we, bus.req_size, c, r);
      n.valid  = 1'b1;
      n.exc    = (c != 0);
      n.code   = (c == 0) ? 5'd0 : (bus.req_we ? 5'd5 : 5'd4);
      n.cause  = 3'(c);
      n.region = 3'(r);
      m_addr   = bus.req_addr;
      m_pc     = bus.req_pc;
    end
    m = n;
    sb_q.push_back(m);
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] pc,
                       input logic st, input logic fl, input logic ack);
    @(negedge clk);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_pc    = pc;
    bus.stall     = st;
    bus.flush     = fl;
    bus.exc_ack   = ack;
    model_step();
  endtask

  task automatic idle(input logic ack);
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, ack);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_chk_valid"}, 32'(bus.chk_valid), 32'h0);
    check({tag, "_chk_exc"}, 32'(bus.chk_exc), 32'h0);
    check({tag, "_chk_exccode"}, 32'(bus.chk_exccode), 32'h0);
    check({tag, "_chk_cause"}, 32'(bus.chk_cause), 32'h0);
    check({tag, "_chk_region"}, 32'(bus.chk_region), 32'h0);
    check({tag, "_pending"}, 32'(bus.fault_pending), 32'h0);
    check({tag, "_bad_vaddr"}, bus.bad_vaddr, 32'h0);
    check({tag, "_bad_pc"}, bus.bad_pc, 32'h0);
    check({tag, "_bad_code"}, 32'(bus.bad_code), 32'h0);
    check({tag, "_drop_cnt"}, 32'(bus.drop_cnt), 32'h0);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.exc_ack   = 1'b0;
    sb_q.delete();
    model_reset();
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  // Monitor: compares every registered output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_chk_valid", 32'(bus.chk_valid), 32'(e.valid));
        check("sb_chk_exc", 32'(bus.chk_exc), 32'(e.exc));
        check("sb_chk_exccode", 32'(bus.chk_exccode), 32'(e.code));
        check("sb_chk_cause", 32'(bus.chk_cause), 32'(e.cause));
        check("sb_chk_region", 32'(bus.chk_region), 32'(e.region));
        check("sb_pending", 32'(bus.fault_pending), 32'(e.pending));
        check("sb_bad_vaddr", bus.bad_vaddr, e.vaddr);
        check("sb_bad_pc", bus.bad_pc, e.pc);
        check("sb_bad_code", 32'(bus.bad_code), 32'(e.bcode));
        check("sb_drop_cnt", 32'(bus.drop_cnt), 32'(e.drop));
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = '0;
    bus.req_pc    = '0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.exc_ack   = 1'b0;
    model_reset();
    #1;
    check_all_zero("por");
    #22;
    reset = 1'b0;

    // Plain word load in RAM.
    drive(1, 0, 2'd2, 32'h1004, 32'h0040_0100, 0, 0, 0);
    settle();
    check("ldw_valid", 32'(bus.chk_valid), 32'h1);
    check("ldw_exc", 32'(bus.chk_exc), 32'h0);
    check("ldw_region", 32'(bus.chk_region), 32'h0);
    check("ldw_code", 32'(bus.chk_exccode), 32'h0);

    // Misaligned half store, then its capture one edge later.
    drive(1, 1, 2'd1, 32'h0003, 32'h0040_0104, 0, 0, 0);
    settle();
    check("sth_exc", 32'(bus.chk_exc), 32'h1);
    check("sth_code", 32'(bus.chk_exccode), 32'h5);
    check("sth_cause", 32'(bus.chk_cause), 32'h4);
    idle(0);
    settle();
    check("sth_pending", 32'(bus.fault_pending), 32'h1);
    check("sth_bad_vaddr", bus.bad_vaddr, 32'h3);
    check("sth_bad_pc", bus.bad_pc, 32'h0040_0104);

    // Store-protected word, then a legal load of the same word.
    drive(1, 1, 2'd2, 32'h7f08, 32'h0040_0108, 0, 0, 0);
    settle();
    check("ro_st_cause", 32'(bus.chk_cause), 32'h5);
    check("ro_st_code", 32'(bus.chk_exccode), 32'h5);
    drive(1, 0, 2'd2, 32'h7f08, 32'h0040_010c, 0, 0, 0);
    settle();
    check("ro_ld_exc", 32'(bus.chk_exc), 32'h0);
    check("ro_ld_region", 32'(bus.chk_region), 32'h1);

    // Byte load in a word-only region; load outside every region.
    drive(1, 0, 2'd0, 32'h7f04, 32'h0040_0110, 0, 0, 0);
    settle();
    check("ldb_cause", 32'(bus.chk_cause), 32'h3);
    check("ldb_code", 32'(bus.chk_exccode), 32'h4);
    drive(1, 0, 2'd2, 32'h4000, 32'h0040_0114, 0, 0, 0);
    settle();
    check("unmap_cause", 32'(bus.chk_cause), 32'h1);
    check("unmap_region", 32'(bus.chk_region), 32'h0);
    idle(0);

    // Three faults unacknowledged, ack coinciding with the fourth.
    async_reset("rst1");
    drive(1, 1, 2'd1, 32'h11, 32'h0040_0200, 0, 0, 0);
    drive(1, 1, 2'd1, 32'h21, 32'h0040_0204, 0, 0, 0);
    drive(1, 1, 2'd1, 32'h31, 32'h0040_0208, 0, 0, 0);
    drive(1, 1, 2'd1, 32'h41, 32'h0040_020c, 0, 0, 0);
    idle(1);
    settle();
    check("ack4_drop", 32'(bus.drop_cnt), 32'h2);
    check("ack4_pending", 32'(bus.fault_pending), 32'h1);
    check("ack4_vaddr", bus.bad_vaddr, 32'h41);

    // Faulting entry held by stall, then flushed: counted at most once.
    idle(1);
    drive(1, 0, 2'd2, 32'h0006, 32'h0040_0300, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(1, 0, 2'd2, 32'h1000, 32'h0040_0304, 1, 0, 0);
    drive(1, 0, 2'd2, 32'h1000, 32'h0040_0304, 1, 1, 0);
    settle();
    check("stall_drop", 32'(bus.drop_cnt), 32'h2);
    check("flush_valid", 32'(bus.chk_valid), 32'h0);
    check("flush_exc", 32'(bus.chk_exc), 32'h0);
    check("stall_vaddr", bus.bad_vaddr, 32'h6);

    async_reset("rst2");

    // Drop counter saturation.
    for (int k = 0; k < 270; k++) drive(1, 0, 2'd2, 32'h4000, 32'(k), 0, 0, 0);
    idle(0);
    settle();
    check("sat_drop", 32'(bus.drop_cnt), 32'hff);

    // Randomized traffic around the region edges and protected words.
    for (int k = 0; k < 2000; k++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 32'h3010);
        1:       a = 32'h7efc + $urandom_range(0, 40);
        2:       a = ro_list[$urandom_range(0, 1)] + $urandom_range(0, 3);
        default: a = $urandom;
      endcase
      sz = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)), sz, a, $urandom,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 20);
    end
    idle(0);
    idle(0);
    settle();
    check("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
